// File: rtl/processor_scheduler.sv
// Time-shares the memory controller, GPU strobe and interrupt controller
// among the screen processors, one enabled at a time.
module processor_scheduler #(
  parameter int NPROC      = 3,
  parameter int GAP_CYCLES = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  output logic [NPROC-1:0]     P_ENABLE,
  input  logic [NPROC-1:0]     P_SWITCH_REQUEST,
  input  logic [NPROC-1:0]     P_FATAL_ERROR,
  input  logic [NPROC-1:0]     P_MEM_ENABLE,
  input  logic [NPROC-1:0]     P_MEM_WRITE,
  input  logic [16*NPROC-1:0]  P_MEM_ADDR,
  input  logic [16*NPROC-1:0]  P_MEM_DATA_W,
  input  logic [NPROC-1:0]     P_GPU_DRAW,
  input  logic [NPROC-1:0]     P_INT_IACK,
  input  logic [NPROC-1:0]     P_INT_IEND,
  output logic [2*NPROC-1:0]   P_INT_IRQ,
  output logic                 MEM_ENABLE,
  output logic                 MEM_WRITE,
  output logic [15:0]          MEM_ADDR,
  output logic [15:0]          MEM_DATA_W,
  output logic                 GPU_DRAW,
  input  logic [1:0]           INT_IRQ,
  output logic                 INT_IACK,
  output logic                 INT_IEND,
  output logic [1:0]           ACTIVE_ID,
  output logic                 HALTED
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [1:0] LAST = 2'(NPROC - 1);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  state_t     state, state_nx;
  logic [1:0] active, active_nx;
  logic [7:0] gap_cnt, gap_nx;
  logic       in_service, in_service_nx;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= BOOT;
      active     <= 2'd0;
      gap_cnt    <= 8'd0;
      in_service <= 1'b0;
    end else begin
      state      <= state_nx;
      active     <= active_nx;
      gap_cnt    <= gap_nx;
      in_service <= in_service_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    active_nx     = active;
    gap_nx        = gap_cnt;
    in_service_nx = in_service;
    P_ENABLE      = '0;
    P_INT_IRQ     = '0;
    MEM_ENABLE    = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDR      = 16'd0;
    MEM_DATA_W    = 16'd0;
    GPU_DRAW      = 1'b0;
    INT_IACK      = 1'b0;
    INT_IEND      = 1'b0;
    HALTED        = 1'b0;
    ACTIVE_ID     = active;
    unique case (state)
      BOOT: state_nx = RUN;
      RUN: begin
        for (int i = 0; i < NPROC; i++) begin
          if (active == 2'(i)) begin
            P_ENABLE[i]         = 1'b1;
            MEM_ENABLE          = P_MEM_ENABLE[i];
            MEM_WRITE           = P_MEM_WRITE[i];
            MEM_ADDR            = P_MEM_ADDR[16*i +: 16];
            MEM_DATA_W          = P_MEM_DATA_W[16*i +: 16];
            GPU_DRAW            = P_GPU_DRAW[i];
            INT_IACK            = P_INT_IACK[i];
            INT_IEND            = P_INT_IEND[i];
            P_INT_IRQ[2*i +: 2] = INT_IRQ;
            if (P_INT_IEND[i])
              in_service_nx = 1'b0;
            else if (P_INT_IACK[i])
              in_service_nx = 1'b1;
            if (P_FATAL_ERROR[i]) begin
              state_nx = HALT;
            end else if (P_SWITCH_REQUEST[i]) begin
              state_nx = DRAIN;
              gap_nx   = GAP_LOAD;
            end
          end
        end
      end
      DRAIN: begin
        // in_service can only be set on entry, so this fires once
        INT_IEND      = in_service;
        in_service_nx = 1'b0;
        if (gap_cnt == 8'd0) begin
          active_nx = (active == LAST) ? 2'd0 : active + 2'd1;
          state_nx  = RUN;
        end else begin
          gap_nx = gap_cnt - 8'd1;
        end
      end
      HALT: HALTED = 1'b1;
      default: state_nx = BOOT;
    endcase
  end

endmodule

// File: tb/tb_processor_scheduler.sv
// Directed plus randomized bench for processor_scheduler against a
// cycle-level behavioural model of the scheduling rules.
module tb_processor_scheduler;

  localparam int NPROC = 3;
  localparam int GAP   = 4;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [2:0]   P_ENABLE;
  logic [2:0]   P_SWITCH_REQUEST;
  logic [2:0]   P_FATAL_ERROR;
  logic [2:0]   P_MEM_ENABLE;
  logic [2:0]   P_MEM_WRITE;
  logic [47:0]  P_MEM_ADDR;
  logic [47:0]  P_MEM_DATA_W;
  logic [2:0]   P_GPU_DRAW;
  logic [2:0]   P_INT_IACK;
  logic [2:0]   P_INT_IEND;
  logic [5:0]   P_INT_IRQ;
  logic         MEM_ENABLE;
  logic         MEM_WRITE;
  logic [15:0]  MEM_ADDR;
  logic [15:0]  MEM_DATA_W;
  logic         GPU_DRAW;
  logic [1:0]   INT_IRQ;
  logic         INT_IACK;
  logic         INT_IEND;
  logic [1:0]   ACTIVE_ID;
  logic         HALTED;

  processor_scheduler #(.NPROC(NPROC), .GAP_CYCLES(GAP)) dut (
    .CLK(CLK), .RESET(RESET),
    .P_ENABLE(P_ENABLE),
    .P_SWITCH_REQUEST(P_SWITCH_REQUEST),
    .P_FATAL_ERROR(P_FATAL_ERROR),
    .P_MEM_ENABLE(P_MEM_ENABLE),
    .P_MEM_WRITE(P_MEM_WRITE),
    .P_MEM_ADDR(P_MEM_ADDR),
    .P_MEM_DATA_W(P_MEM_DATA_W),
    .P_GPU_DRAW(P_GPU_DRAW),
    .P_INT_IACK(P_INT_IACK),
    .P_INT_IEND(P_INT_IEND),
    .P_INT_IRQ(P_INT_IRQ),
    .MEM_ENABLE(MEM_ENABLE),
    .MEM_WRITE(MEM_WRITE),
    .MEM_ADDR(MEM_ADDR),
    .MEM_DATA_W(MEM_DATA_W),
    .GPU_DRAW(GPU_DRAW),
    .INT_IRQ(INT_IRQ),
    .INT_IACK(INT_IACK),
    .INT_IEND(INT_IEND),
    .ACTIVE_ID(ACTIVE_ID),
    .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  int compared   = 0;
  int mismatched = 0;

  // model: mode 0 boot, 1 run, 2 drain, 3 halt
  int m_mode;
  int m_act;
  int m_left;
  bit m_ins;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_act  = 0;
    m_left = 0;
    m_ins  = 0;
  endtask

  task automatic check_model();
    bit          run;
    logic [2:0]  e_en;
    logic [5:0]  e_irq;
    run   = (m_mode == 1);
    e_en  = run ? 3'(1 << m_act) : 3'd0;
    e_irq = run ? 6'(int'(INT_IRQ) << (2 * m_act)) : 6'd0;
    chk("p_enable", 64'(P_ENABLE), 64'(e_en));
    chk("p_int_irq", 64'(P_INT_IRQ), 64'(e_irq));
    chk("mem_enable", 64'(MEM_ENABLE),
        run ? 64'(P_MEM_ENABLE[m_act]) : 64'd0);
    chk("mem_write", 64'(MEM_WRITE),
        run ? 64'(P_MEM_WRITE[m_act]) : 64'd0);
    chk("mem_addr", 64'(MEM_ADDR),
        run ? 64'(P_MEM_ADDR[16*m_act +: 16]) : 64'd0);
    chk("mem_data_w", 64'(MEM_DATA_W),
        run ? 64'(P_MEM_DATA_W[16*m_act +: 16]) : 64'd0);
    chk("gpu_draw", 64'(GPU_DRAW),
        run ? 64'(P_GPU_DRAW[m_act]) : 64'd0);
    chk("int_iack", 64'(INT_IACK),
        run ? 64'(P_INT_IACK[m_act]) : 64'd0);
    chk("int_iend", 64'(INT_IEND),
        run ? 64'(P_INT_IEND[m_act]) :
        (m_mode == 2 && m_ins) ? 64'd1 : 64'd0);
    chk("active_id", 64'(ACTIVE_ID), 64'(m_act));
    chk("halted", 64'(HALTED), (m_mode == 3) ? 64'd1 : 64'd0);
  endtask

  task automatic model_adv();
    case (m_mode)
      0: m_mode = 1;
      1: begin
        if (P_INT_IEND[m_act]) m_ins = 0;
        else if (P_INT_IACK[m_act]) m_ins = 1;
        if (P_FATAL_ERROR[m_act]) begin
          m_mode = 3;
        end else if (P_SWITCH_REQUEST[m_act]) begin
          m_mode = 2;
          m_left = GAP;
        end
      end
      2: begin
        m_ins  = 0;
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_act  = (m_act + 1) % NPROC;
          m_mode = 1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic step();
    #1;
    check_model();
    model_adv();
    @(negedge CLK);
  endtask

  task automatic clear_inputs();
    P_SWITCH_REQUEST = '0;
    P_FATAL_ERROR    = '0;
    P_MEM_ENABLE     = '0;
    P_MEM_WRITE      = '0;
    P_MEM_ADDR       = '0;
    P_MEM_DATA_W     = '0;
    P_GPU_DRAW       = '0;
    P_INT_IACK       = '0;
    P_INT_IEND       = '0;
    INT_IRQ          = '0;
  endtask

  task automatic rand_inputs(input bit allow_sw);
    P_MEM_ENABLE = 3'($urandom);
    P_MEM_WRITE  = 3'($urandom);
    P_MEM_ADDR   = {$urandom, $urandom};
    P_MEM_DATA_W = {$urandom, $urandom};
    P_GPU_DRAW   = 3'($urandom);
    P_INT_IACK   = 3'($urandom);
    P_INT_IEND   = 3'($urandom) & ~P_INT_IACK;
    INT_IRQ      = 2'($urandom);
    P_SWITCH_REQUEST = '0;
    for (int i = 0; i < NPROC; i++)
      if (allow_sw && $urandom_range(0, 7) == 0)
        P_SWITCH_REQUEST[i] = 1'b1;
    // fatal errors only from processors that should be ignored
    P_FATAL_ERROR = 3'($urandom) & ~3'(1 << m_act);
  endtask

  // runs one DRAIN from the current negedge; returns low-enable cycles
  task automatic count_drain(output int low);
    low = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (P_ENABLE != 3'd0) break;
      low++;
      check_model();
      model_adv();
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic do_switch(input logic [2:0] sw, input logic [2:0] en_exp,
                           input logic [1:0] id_exp);
    int low;
    clear_inputs();
    P_SWITCH_REQUEST = sw;
    step();
    clear_inputs();
    count_drain(low);
    chk("drain_len", 64'(low), 64'(GAP));
    chk("switch_enable", 64'(P_ENABLE), 64'(en_exp));
    chk("switch_id", 64'(ACTIVE_ID), 64'(id_exp));
    step();
  endtask

  initial begin
    int guard;
    RESET = 1'b0;
    clear_inputs();
    model_reset();
    #3;
    check_model();
    chk("reset_enable", 64'(P_ENABLE), 64'd0);
    @(negedge CLK);
    RESET = 1'b1;
    step();

    P_MEM_ADDR   = {16'h0000, 16'hFFFF, 16'h0800};
    P_MEM_ENABLE = 3'b011;
    INT_IRQ      = 2'b01;
    #1;
    chk("boot_enable", 64'(P_ENABLE), 64'h1);
    chk("boot_id", 64'(ACTIVE_ID), 64'h0);
    chk("p0_addr", 64'(MEM_ADDR), 64'h0800);
    chk("p0_mem_en", 64'(MEM_ENABLE), 64'h1);
    chk("p0_irq", 64'(P_INT_IRQ), 64'h01);
    step();

    do_switch(3'b001, 3'b010, 2'd1);
    do_switch(3'b010, 3'b100, 2'd2);
    do_switch(3'b100, 3'b001, 2'd0);

    clear_inputs();
    P_INT_IACK = 3'b001;
    step();
    clear_inputs();
    P_SWITCH_REQUEST = 3'b001;
    step();
    clear_inputs();
    #1;
    chk("iend_first_drain", 64'(INT_IEND), 64'h1);
    step();
    #1;
    chk("iend_second_drain", 64'(INT_IEND), 64'h0);
    guard = 0;
    while (m_mode != 1 && guard < 20) begin
      step();
      guard++;
    end
    chk("iend_drain_done", 64'(guard < 20), 64'h1);

    for (int c = 0; c < 400; c++) begin
      rand_inputs(1'b1);
      step();
    end

    guard = 0;
    clear_inputs();
    while (!(m_mode == 1 && m_act == 1) && guard < 60) begin
      P_SWITCH_REQUEST = (m_mode == 1) ? 3'b111 : 3'b000;
      step();
      guard++;
    end
    chk("reach_p1", 64'(guard < 60), 64'h1);
    clear_inputs();
    P_FATAL_ERROR    = 3'b010;
    P_SWITCH_REQUEST = 3'b010;
    step();
    clear_inputs();
    #1;
    chk("halt_halted", 64'(HALTED), 64'h1);
    chk("halt_enable", 64'(P_ENABLE), 64'h0);
    chk("halt_id", 64'(ACTIVE_ID), 64'h1);
    for (int c = 0; c < 8; c++) begin
      rand_inputs(1'b0);
      P_SWITCH_REQUEST = 3'b111;
      step();
    end

    #2;
    RESET = 1'b0;
    #1;
    model_reset();
    chk("halt_reset_halted", 64'(HALTED), 64'h0);
    chk("halt_reset_id", 64'(ACTIVE_ID), 64'h0);
    @(negedge CLK);
    RESET = 1'b1;
    clear_inputs();
    step();

    P_INT_IACK = 3'b001;
    step();
    clear_inputs();
    P_SWITCH_REQUEST = 3'b001;
    step();
    clear_inputs();
    #1;
    chk("pre_reset_iend", 64'(INT_IEND), 64'h1);
    RESET = 1'b0;
    #1;
    model_reset();
    check_model();
    chk("drain_reset_iend", 64'(INT_IEND), 64'h0);
    @(negedge CLK);
    RESET = 1'b1;
    step();
    #1;
    chk("post_reset_enable", 64'(P_ENABLE), 64'h1);
    chk("post_reset_id", 64'(ACTIVE_ID), 64'h0);
    for (int c = 0; c < 100; c++) begin
      rand_inputs(1'b1);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/processor_scheduler.md
Name: processor_scheduler

Overview:
- Owns the shared memory controller, GPU draw strobe and interrupt controller on behalf of the screen processors (title, game, game-over).
- Exactly one processor is enabled at a time. The enabled processor is the only one whose bus is routed to the shared resources.
- A processor's SWITCH_REQUEST hands control to the next processor after a drain gap.
- A FATAL_ERROR from the enabled processor freezes the system.

Parameters:
- NPROC, 3, number of processors; index 0 is title and is active after reset.
- GAP_CYCLES, 4, idle cycles in DRAIN, with all ENABLE low, before the next processor is enabled; legal range 1-255.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RESET  in  1  asynchronous, active-low reset; clears all state immediately when low.
- P_ENABLE  out  NPROC  one-hot enable, one bit per processor.
- P_SWITCH_REQUEST  in  NPROC  switch request from each processor.
- P_FATAL_ERROR  in  NPROC  fatal error from each processor.
- P_MEM_ENABLE  in  NPROC  per-processor memory enable.
- P_MEM_WRITE  in  NPROC  per-processor memory write.
- P_MEM_ADDR  in  16*NPROC  per-processor address; processor i uses bits [16i+15:16i].
- P_MEM_DATA_W  in  16*NPROC  per-processor write data; same packing as P_MEM_ADDR.
- P_GPU_DRAW  in  NPROC  per-processor draw strobe.
- P_INT_IACK  in  NPROC  per-processor interrupt acknowledge.
- P_INT_IEND  in  NPROC  per-processor interrupt end.
- P_INT_IRQ  out  2*NPROC  IRQ code routed to each processor.
- MEM_ENABLE, MEM_WRITE  out  1  to memory controller.
- MEM_ADDR, MEM_DATA_W  out  16  to memory controller.
- GPU_DRAW  out  1  to graphic controller.
- INT_IRQ  in  2  from interrupt controller.
- INT_IACK, INT_IEND  out  1  to interrupt controller.
- ACTIVE_ID  out  2  index of the selected processor.
- HALTED  out  1  high after a fatal error.

Behaviour:
- Registers:
  - state: BOOT / RUN / DRAIN / HALT.
  - active[1:0]: selected processor.
  - gapCnt[7:0]: DRAIN counter.
  - inService: set when INT_IACK is driven; cleared when INT_IEND is driven.
- Reset (RESET low, asynchronous):
  - state=BOOT, active=0, gapCnt=0, inService=0.
  - All outputs 0: P_ENABLE=0, MEM_*=0, GPU_DRAW=0, INT_IACK=0, INT_IEND=0, P_INT_IRQ=0, ACTIVE_ID=0, HALTED=0.
  - A reset mid-DRAIN or in HALT returns the block to this state.
- BOOT: everything idle for 1 cycle, then RUN.
- RUN:
  - P_ENABLE = one-hot(active).
  - MEM_ENABLE, MEM_WRITE, MEM_ADDR, MEM_DATA_W, GPU_DRAW, INT_IACK and INT_IEND are combinational copies of the active processor's inputs.
  - The IRQ slice of the active processor = INT_IRQ; all other slices = 0.
  - Inputs from non-active processors are ignored, including their SWITCH_REQUEST and FATAL_ERROR.
- RUN exits, evaluated in priority order:
  1. P_FATAL_ERROR[active]=1 → HALT.
  2. P_SWITCH_REQUEST[active]=1 → DRAIN, with gapCnt loaded to GAP_CYCLES-1. If both are high in the same cycle, the fatal error wins.
- DRAIN:
  - P_ENABLE=0, which resets the FSM of the outgoing processor.
  - MEM_ENABLE=0, GPU_DRAW=0, INT_IACK=0, all P_INT_IRQ=0.
  - First DRAIN cycle only: if inService=1, INT_IEND=1 for one cycle and inService is cleared. This keeps the interrupt controller from hanging on an unfinished acknowledge.
  - gapCnt decrements each cycle. In the cycle gapCnt=0: active ← (active==NPROC-1) ? 0 : active+1, and state → RUN.
  - DRAIN therefore lasts exactly GAP_CYCLES cycles. The new processor sees ENABLE=1 on the next edge.
  - All processor inputs are ignored during DRAIN.
- HALT:
  - P_ENABLE=0, all shared outputs 0, HALTED=1.
  - ACTIVE_ID keeps the index of the failing processor.
  - Only RESET exits HALT.
- ACTIVE_ID = active in every state.
- Bus muxing is combinational: zero added latency to the memory and GPU paths.

Test Plan:
- Release RESET; hold P_SWITCH_REQUEST=0 → BOOT lasts 1 cycle, then P_ENABLE=3'b001 and ACTIVE_ID=0. With P_MEM_ADDR[15:0]=16'h0800 and P_MEM_ENABLE[0]=1: MEM_ADDR=16'h0800 and MEM_ENABLE=1 in the same cycle.
- P_MEM_ENABLE[1]=1 and P_MEM_ADDR[31:16]=16'hFFFF while processor 0 is active → MEM_ENABLE and MEM_ADDR still follow processor 0. With INT_IRQ=2'b01: P_INT_IRQ=6'b000001.
- 1-cycle P_SWITCH_REQUEST[0] → P_ENABLE=0 for exactly 4 cycles (GAP_CYCLES=4), then P_ENABLE=3'b010 and ACTIVE_ID=1. Repeating the switch from processor 2 wraps to 3'b001.
- Processor 0 drives P_INT_IACK[0]=1, then requests a switch before driving P_INT_IEND → INT_IEND=1 for exactly one cycle in the first DRAIN cycle.
- P_FATAL_ERROR[1] and P_SWITCH_REQUEST[1] high together while processor 1 is active → HALT: HALTED=1, P_ENABLE=0, ACTIVE_ID=1. A subsequent switch request has no effect.
- Pull RESET low in the middle of DRAIN → all outputs 0 immediately, without waiting for CLK. After release: BOOT, then processor 0 is active.
